// File: rtl/memstream_rd_sched.sv
// memstream_rd_sched: walks an address window of a 2-cycle-latency block RAM
// a configurable number of times and streams the words out with backpressure.
module memstream_rd_sched #(
   parameter int unsigned DWIDTH     = 18,
   parameter int unsigned AWIDTH     = 10,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [AWIDTH-1:0] cfg_base,
   input  logic [AWIDTH:0]   cfg_len,
   input  logic [15:0]       cfg_reps,
   output logic [AWIDTH-1:0] ram_addr,
   input  logic [DWIDTH-1:0] ram_rdq,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [DWIDTH-1:0] m_tdata,
   output logic              busy,
   output logic              done
);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = $clog2(FIFO_DEPTH + 4) + 1;
   localparam int unsigned LW = AWIDTH + 1;
   localparam int unsigned RW = 16;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] base_q, base_d;
   logic [LW-1:0]     len_q, len_d, off_q, off_d;
   logic [RW-1:0]     reps_q, reps_d, rep_q, rep_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic              iss_q, iss_d;
   logic [1:0]        vld_q, vld_d;
   logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DWIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_left;
   logic              tvalid_q, tvalid_d;
   logic [DWIDTH-1:0] tdata_q, tdata_d;
   logic              busy_q, busy_d, done_q, done_d;

   logic              pop, push, flush, issue, idle;
   logic [AWIDTH-1:0] cur_base;
   logic [LW-1:0]     cur_len, cur_off;
   logic [RW-1:0]     cur_reps, cur_rep;
   logic              last_off, last_rep;
   logic [SW-1:0]     outstanding;

   assign pop  = tvalid_q & m_tready;
   assign push = vld_q[1];

   // Sequencer: job control, credit-based issue and window walk
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      reps_d   = reps_q;
      off_d    = off_q;
      rep_d    = rep_q;
      addr_d   = addr_q;
      iss_d    = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      flush    = 1'b0;
      issue    = 1'b0;
      idle     = (state_q == S_IDLE);
      cur_base = idle ? cfg_base : base_q;
      cur_len  = idle ? cfg_len  : len_q;
      cur_reps = idle ? cfg_reps : reps_q;
      cur_off  = idle ? '0 : off_q;
      cur_rep  = idle ? '0 : rep_q;
      last_off = (cur_off == cur_len - LW'(1));
      last_rep = (cur_reps != '0) && (cur_rep == cur_reps - RW'(1));
      // words that will be held in flight or buffered after this edge, before a new issue
      outstanding = SW'(cnt_q) - SW'(pop) + SW'(push) + SW'(vld_q[0]) + SW'(iss_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  base_d  = cfg_base;
                  len_d   = cfg_len;
                  reps_d  = cfg_reps;
                  issue   = 1'b1;
                  busy_d  = 1'b1;
                  state_d = (last_off && last_rep) ? S_DRAIN : S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               flush   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (outstanding < SW'(FIFO_DEPTH)) begin
               issue = 1'b1;
               if (last_off && last_rep) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               flush   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (done_q) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (!iss_q && (vld_q == 2'b00) && (cnt_left == '0)) begin
               done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (issue) begin
         addr_d = cur_base + AWIDTH'(cur_off);
         iss_d  = 1'b1;
         off_d  = last_off ? '0 : cur_off + LW'(1);
         rep_d  = last_off ? cur_rep + RW'(1) : cur_rep;
      end
   end

   // Latency tracking and output FIFO with a registered head word
   always_comb begin
      mem_d    = mem_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      vld_d    = {vld_q[0], iss_q};
      tdata_d  = tdata_q;
      cnt_left = cnt_q - CW'(pop);
      if (push) begin
         mem_d[wr_q] = ram_rdq;
         wr_d        = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_left + CW'(push);
      if (cnt_left == '0) begin
         if (push) tdata_d = ram_rdq;
      end else begin
         tdata_d = mem_q[rd_d];
      end
      tvalid_d = (cnt_d != '0);
      if (flush) begin
         wr_d     = '0;
         rd_d     = '0;
         cnt_d    = '0;
         vld_d    = '0;
         tvalid_d = 1'b0;
      end
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         reps_q   <= '0;
         off_q    <= '0;
         rep_q    <= '0;
         addr_q   <= '0;
         iss_q    <= 1'b0;
         vld_q    <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         len_q    <= len_d;
         reps_q   <= reps_d;
         off_q    <= off_d;
         rep_q    <= rep_d;
         addr_q   <= addr_d;
         iss_q    <= iss_d;
         vld_q    <= vld_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset needed
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign ram_addr = addr_q;
   assign m_tvalid = tvalid_q;
   assign m_tdata  = tdata_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
